// File: rtl/zcnt_shifter.sv
// Normalising shifter driven by a zero count: right-shift by trailing zeros (MODE=0)
// or left-shift by leading zeros (MODE=1), as a 2-stage valid/ready pipeline.
module zcnt_shifter #(
    parameter int   WIDTH     = 53,
    parameter logic MODE      = 1'b0,
    parameter int   CNT_WIDTH = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [WIDTH-1:0]     data_i,
    input  logic [CNT_WIDTH-1:0] cnt_i,
    input  logic                 empty_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [WIDTH-1:0]     data_o,
    output logic [CNT_WIDTH-1:0] shamt_o,
    output logic                 sticky_o,
    output logic                 err_o,
    output logic                 zero_o
);

    localparam logic [CNT_WIDTH-1:0] SAT       = CNT_WIDTH'(WIDTH);
    localparam logic [CNT_WIDTH-1:0] FINE_MASK = CNT_WIDTH'(7);

    logic                 s1_valid, s2_valid;
    logic                 s1_adv, s2_adv;
    logic [WIDTH-1:0]     s1_data, s2_data;
    logic [CNT_WIDTH-1:0] s1_shamt, s2_shamt;
    logic                 s1_flag;
    logic                 s2_sticky, s2_err, s2_zero;

    assign s2_adv  = s1_valid && (!s2_valid || ready_i);
    assign ready_o = !s1_valid || s2_adv;
    assign s1_adv  = valid_i && ready_o;

    // Stage 1: saturate, then shift by the multiple-of-8 part of the amount
    logic [CNT_WIDTH-1:0] shamt, coarse;
    logic [WIDTH-1:0]     ones, coarse_data, coarse_lost;
    logic                 coarse_flag;

    always_comb begin
        shamt       = (empty_i || (cnt_i >= SAT)) ? SAT : cnt_i;
        coarse      = shamt & ~FINE_MASK;
        ones        = '1;
        coarse_data = '0;
        coarse_lost = '0;
        if (MODE) begin
            coarse_data = data_i << coarse;
            coarse_lost = ~(ones >> coarse);
        end else begin
            coarse_data = data_i >> coarse;
            coarse_lost = ~(ones << coarse);
        end
        coarse_flag = |(data_i & coarse_lost);
    end

    // Stage 2: residual shift by the low three bits, folding in the stage-1 flag
    logic [CNT_WIDTH-1:0] fine;
    logic [WIDTH-1:0]     fine_data, fine_lost;
    logic                 fine_flag;

    always_comb begin
        fine      = s1_shamt & FINE_MASK;
        fine_data = '0;
        fine_lost = '0;
        if (MODE) begin
            fine_data = s1_data << fine;
            fine_lost = ~(ones >> fine);
        end else begin
            fine_data = s1_data >> fine;
            fine_lost = ~(ones << fine);
        end
        fine_flag = s1_flag | (|(s1_data & fine_lost));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (ready_o) s1_valid <= valid_i;
            if (s2_adv) s2_valid <= 1'b1;
            else if (ready_i) s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (s1_adv) begin
            s1_data  <= coarse_data;
            s1_shamt <= shamt;
            s1_flag  <= coarse_flag;
        end
        if (s2_adv) begin
            s2_data   <= fine_data;
            s2_shamt  <= s1_shamt;
            s2_sticky <= MODE ? 1'b0 : fine_flag;
            s2_err    <= MODE ? fine_flag : 1'b0;
            s2_zero   <= ~|fine_data;
        end
    end

    assign valid_o  = s2_valid;
    assign data_o   = s2_data;
    assign shamt_o  = s2_shamt;
    assign sticky_o = s2_valid & s2_sticky;
    assign err_o    = s2_valid & s2_err;
    assign zero_o   = s2_valid & s2_zero;

endmodule

// File: tb/tb_zcnt_shifter.sv
// Scoreboard bench: an 8-bit right-shift instance and a 53-bit left-shift instance.
module tb_zcnt_shifter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       a_valid_i = 1'b0, a_ready_o, a_empty_i = 1'b0, a_valid_o, a_ready_i = 1'b1;
    logic [7:0] a_data_i = '0, a_data_o;
    logic [3:0] a_cnt_i = '0, a_shamt_o;
    logic       a_sticky_o, a_err_o, a_zero_o;

    logic        b_valid_i = 1'b0, b_ready_o, b_empty_i = 1'b0, b_valid_o, b_ready_i = 1'b1;
    logic [52:0] b_data_i = '0, b_data_o;
    logic [5:0]  b_cnt_i = '0, b_shamt_o;
    logic        b_sticky_o, b_err_o, b_zero_o;

    zcnt_shifter #(.WIDTH(8), .MODE(1'b0), .CNT_WIDTH(4)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(a_valid_i), .ready_o(a_ready_o),
        .data_i(a_data_i), .cnt_i(a_cnt_i), .empty_i(a_empty_i), .valid_o(a_valid_o),
        .ready_i(a_ready_i), .data_o(a_data_o), .shamt_o(a_shamt_o), .sticky_o(a_sticky_o),
        .err_o(a_err_o), .zero_o(a_zero_o)
    );

    zcnt_shifter #(.WIDTH(53), .MODE(1'b1), .CNT_WIDTH(6)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(b_valid_i), .ready_o(b_ready_o),
        .data_i(b_data_i), .cnt_i(b_cnt_i), .empty_i(b_empty_i), .valid_o(b_valid_o),
        .ready_i(b_ready_i), .data_o(b_data_o), .shamt_o(b_shamt_o), .sticky_o(b_sticky_o),
        .err_o(b_err_o), .zero_o(b_zero_o)
    );

    typedef struct {
        logic [63:0] data;
        logic [7:0]  shamt;
        logic        flag;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    typedef struct packed {
        logic [7:0] d; logic [3:0] c; logic e; logic [7:0] xd; logic [3:0] xs; logic xf;
    } va_t;
    typedef struct packed {
        logic [52:0] d; logic [5:0] c; logic e; logic [52:0] xd; logic [5:0] xs; logic xf;
    } vb_t;

    // Expected values worked out by hand: xd = shifted data, xs = shamt, xf = sticky (A) / err (B)
    va_t va [12] = '{
        '{8'hB4, 4'd3,  1'b0, 8'h16, 4'd3, 1'b1},
        '{8'hB4, 4'd2,  1'b0, 8'h2D, 4'd2, 1'b0},
        '{8'hB4, 4'd0,  1'b0, 8'hB4, 4'd0, 1'b0},
        '{8'hB4, 4'd7,  1'b0, 8'h01, 4'd7, 1'b1},
        '{8'hB4, 4'd8,  1'b0, 8'h00, 4'd8, 1'b1},
        '{8'hB4, 4'd15, 1'b0, 8'h00, 4'd8, 1'b1},
        '{8'h00, 4'd0,  1'b1, 8'h00, 4'd8, 1'b0},
        '{8'h80, 4'd5,  1'b0, 8'h04, 4'd5, 1'b0},
        '{8'h81, 4'd1,  1'b0, 8'h40, 4'd1, 1'b1},
        '{8'hFF, 4'd4,  1'b0, 8'h0F, 4'd4, 1'b1},
        '{8'h0F, 4'd4,  1'b0, 8'h00, 4'd4, 1'b1},
        '{8'hA5, 4'd2,  1'b1, 8'h00, 4'd8, 1'b1}
    };

    vb_t vb [14] = '{
        '{53'h0C_0000_0000_0000, 6'd1,  1'b0, 53'h18_0000_0000_0000, 6'd1,  1'b0},
        '{53'h0C_0000_0000_0000, 6'd2,  1'b0, 53'h10_0000_0000_0000, 6'd2,  1'b1},
        '{53'h1,                 6'd52, 1'b0, 53'h10_0000_0000_0000, 6'd52, 1'b0},
        '{53'h1,                 6'd60, 1'b0, 53'h0,                 6'd53, 1'b1},
        '{53'h1,                 6'd0,  1'b1, 53'h0,                 6'd53, 1'b1},
        '{53'h1,                 6'd53, 1'b0, 53'h0,                 6'd53, 1'b1},
        '{53'h0,                 6'd0,  1'b1, 53'h0,                 6'd53, 1'b0},
        '{53'h1F_FFFF_FFFF_FFFF, 6'd0,  1'b0, 53'h1F_FFFF_FFFF_FFFF, 6'd0,  1'b0},
        '{53'hFF,                6'd8,  1'b0, 53'hFF00,              6'd8,  1'b0},
        '{53'hFF,                6'd13, 1'b0, 53'h1F_E000,           6'd13, 1'b0},
        '{53'h1F_0000_0000_0000, 6'd4,  1'b0, 53'h10_0000_0000_0000, 6'd4,  1'b1},
        '{53'h00_8000_0000_0001, 6'd5,  1'b0, 53'h10_0000_0000_0020, 6'd5,  1'b0},
        '{53'h00_8000_0000_0001, 6'd6,  1'b0, 53'h40,                6'd6,  1'b1},
        '{53'h12_3456_789A_BCDE, 6'd16, 1'b0, 53'h16_789A_BCDE_0000, 6'd16, 1'b1}
    };

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout/unexpected expected none", name);
    endtask

    task automatic send_a(input va_t v, input bit push);
        int  waited;
        bit  acc;
        exp_t x;
        waited = 0;
        a_data_i = v.d; a_cnt_i = v.c; a_empty_i = v.e; a_valid_i = 1'b1;
        do begin
            @(negedge clk);
            acc = a_ready_o;
            @(posedge clk);
            #1;
            waited++;
        end while (!acc && waited < 50);
        a_valid_i = 1'b0;
        if (!acc) fail_now("a_accept");
        else if (push) begin
            x.data = 64'(v.xd); x.shamt = 8'(v.xs); x.flag = v.xf;
            qa.push_back(x);
        end
    endtask

    task automatic send_b(input vb_t v, input bit push);
        int  waited;
        bit  acc;
        exp_t x;
        waited = 0;
        b_data_i = v.d; b_cnt_i = v.c; b_empty_i = v.e; b_valid_i = 1'b1;
        do begin
            @(negedge clk);
            acc = b_ready_o;
            @(posedge clk);
            #1;
            waited++;
        end while (!acc && waited < 50);
        b_valid_i = 1'b0;
        if (!acc) fail_now("b_accept");
        else if (push) begin
            x.data = 64'(v.xd); x.shamt = 8'(v.xs); x.flag = v.xf;
            qb.push_back(x);
        end
    endtask

    // Monitors: pop on each transfer, check output stability while stalled
    logic       a_hold = 1'b0;
    logic [7:0] a_hd;
    logic [3:0] a_hs;
    logic       a_hf, a_hz;

    always @(negedge clk) begin
        if (!rst_n) begin
            a_hold <= 1'b0;
        end else begin
            if (a_hold && a_valid_o) begin
                check("a_hold_data", 64'(a_data_o), 64'(a_hd));
                check("a_hold_shamt", 64'(a_shamt_o), 64'(a_hs));
                check("a_hold_flags", 64'({a_sticky_o, a_zero_o}), 64'({a_hf, a_hz}));
            end
            if (a_valid_o && a_ready_i) begin
                if (qa.size() == 0) fail_now("a_unexpected_output");
                else begin
                    check("a_data", 64'(a_data_o), qa[0].data);
                    check("a_shamt", 64'(a_shamt_o), 64'(qa[0].shamt));
                    check("a_sticky", 64'(a_sticky_o), 64'(qa[0].flag));
                    check("a_err", 64'(a_err_o), 64'(0));
                    check("a_zero", 64'(a_zero_o), 64'(qa[0].data == 64'd0));
                    void'(qa.pop_front());
                end
            end
            if (!a_valid_o) check("a_idle_flags", 64'({a_sticky_o, a_err_o, a_zero_o}), 64'(0));
            a_hold <= a_valid_o && !a_ready_i;
            a_hd <= a_data_o; a_hs <= a_shamt_o; a_hf <= a_sticky_o; a_hz <= a_zero_o;
        end
    end

    logic        b_hold = 1'b0;
    logic [52:0] b_hd;
    logic [5:0]  b_hs;
    logic        b_hf, b_hz;

    always @(negedge clk) begin
        if (!rst_n) begin
            b_hold <= 1'b0;
        end else begin
            if (b_hold && b_valid_o) begin
                check("b_hold_data", 64'(b_data_o), 64'(b_hd));
                check("b_hold_shamt", 64'(b_shamt_o), 64'(b_hs));
                check("b_hold_flags", 64'({b_err_o, b_zero_o}), 64'({b_hf, b_hz}));
            end
            if (b_valid_o && b_ready_i) begin
                if (qb.size() == 0) fail_now("b_unexpected_output");
                else begin
                    check("b_data", 64'(b_data_o), qb[0].data);
                    check("b_shamt", 64'(b_shamt_o), 64'(qb[0].shamt));
                    check("b_err", 64'(b_err_o), 64'(qb[0].flag));
                    check("b_sticky", 64'(b_sticky_o), 64'(0));
                    check("b_zero", 64'(b_zero_o), 64'(qb[0].data == 64'd0));
                    void'(qb.pop_front());
                end
            end
            if (!b_valid_o) check("b_idle_flags", 64'({b_sticky_o, b_err_o, b_zero_o}), 64'(0));
            b_hold <= b_valid_o && !b_ready_i;
            b_hd <= b_data_o; b_hs <= b_shamt_o; b_hf <= b_err_o; b_hz <= b_zero_o;
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_a_valid", 64'(a_valid_o), 64'(0));
        check("rst_a_ready", 64'(a_ready_o), 64'(1));
        check("rst_b_valid", 64'(b_valid_o), 64'(0));
        check("rst_b_ready", 64'(b_ready_o), 64'(1));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Latency: result appears in the second cycle after acceptance
        send_a(va[0], 1'b1);
        @(negedge clk);
        check("a_latency_c1", 64'(a_valid_o), 64'(0));
        @(negedge clk);
        check("a_latency_c2", 64'(a_valid_o), 64'(1));
        @(posedge clk);
        #1;

        for (int i = 1; i < 12; i++) send_a(va[i], 1'b1);
        for (int i = 0; i < 14; i++) send_b(vb[i], 1'b1);
        repeat (4) @(posedge clk);
        #1;

        // Backpressure: three back-to-back requests against a stalled consumer
        a_ready_i = 1'b0;
        fork
            begin
                send_a(va[0], 1'b1);
                send_a(va[1], 1'b1);
                send_a(va[2], 1'b1);
            end
            begin
                repeat (4) @(negedge clk);
                check("bp_ready_low", 64'(a_ready_o), 64'(0));
                check("bp_valid_high", 64'(a_valid_o), 64'(1));
                check("bp_head_data", 64'(a_data_o), 64'(8'h16));
                @(posedge clk);
                #1 a_ready_i = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("bp_consecutive", 64'(a_valid_o), 64'(1));
                end
            end
        join
        repeat (5) @(posedge clk);
        #1;

        // Reset with two requests in flight: neither may emerge afterwards
        b_ready_i = 1'b0;
        send_b(vb[0], 1'b0);
        send_b(vb[1], 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        b_ready_i = 1'b1;
        @(negedge clk);
        check("midrst_b_valid", 64'(b_valid_o), 64'(0));
        check("midrst_b_ready", 64'(b_ready_o), 64'(1));
        @(posedge clk);
        #1;
        send_b(vb[13], 1'b1);
        @(negedge clk);
        check("b_latency_c1", 64'(b_valid_o), 64'(0));
        @(negedge clk);
        check("b_latency_c2", 64'(b_valid_o), 64'(1));

        begin
            int w;
            w = 0;
            while ((qa.size() != 0 || qb.size() != 0) && w < 100) begin
                @(posedge clk);
                w++;
            end
            if (qa.size() != 0 || qb.size() != 0) fail_now("drain");
        end
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
